// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority-vote bit sampling and a held output word.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] MID_LO    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] MID       = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] MID_HI    = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] ALL_BITS  = BW'(DATA_BITS);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [1:0]             samp_q, samp_d;
    logic                   vote;
    logic                   ferr_q, ferr_d;
    logic                   armed_q, armed_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   dv_q, dv_d;
    logic                   oferr_q, oferr_d;
    logic                   ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic                   perr_q, perr_d;
    logic                   operr_q, operr_d;
`else
    logic                   unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    // Two earlier samples of the bit plus the live one form the 2-of-3 vote.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            samp_q  <= '1;
            ferr_q  <= 1'b0;
            armed_q <= 1'b1;
            data_q  <= '0;
            dv_q    <= 1'b0;
            oferr_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
            operr_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            samp_q  <= samp_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            oferr_q <= oferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
            operr_q <= operr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        samp_d  = samp_q;
        ferr_d  = ferr_q;
        armed_d = armed_q;
        data_d  = data_q;
        dv_d    = dv_q;
        oferr_d = oferr_q;
        ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
        operr_d = operr_q;
`endif

        if (baud_tick) begin
            if (cnt_q == MID_LO) samp_d[0] = rx_s;
            if (cnt_q == MID)    samp_d[1] = rx_s;
            if (state_q != S_IDLE) begin
                cnt_d = (cnt_q == LAST_TICK) ? '0 : cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                // After a break the line must be seen high before a new start is armed.
                if (baud_tick) begin
                    if (!armed_q) begin
                        armed_d = rx_s;
                    end else if (!rx_s) begin
                        state_d = S_START;
                        cnt_d   = CW'(1);
                        bcnt_d  = '0;
                        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_d  = 1'b0;
`endif
                    end
                end
            end
            S_START: begin
                if (baud_tick) begin
                    if (cnt_q == MID && rx_s) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == LAST_TICK) begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (cnt_q == MID_HI) begin
                        shift_d = {vote, shift_q[DATA_BITS-1:1]};
                        bcnt_d  = bcnt_q + 1'b1;
                    end
                    if (cnt_q == LAST_TICK && bcnt_q == ALL_BITS) begin
                        bcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    if (cnt_q == MID_HI) begin
                        perr_d = vote ^ (^shift_q) ^ parity_odd;
                    end
                    if (cnt_q == LAST_TICK) begin
                        state_d = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                // Leave at the mid-sample of the last stop bit so a new start edge is caught at once.
                if (baud_tick && cnt_q == MID_HI) begin
                    if (!vote) ferr_d = 1'b1;
                    if (bcnt_q == LAST_STOP) begin
                        state_d = S_DONE;
                        armed_d = vote;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q == S_DONE) begin
            if (!dv_q || data_ready) begin
                data_d  = shift_q;
                oferr_d = ferr_q;
`ifdef UART_RX_PARITY_EN
                operr_d = perr_q;
`endif
                dv_d    = 1'b1;
                if (dv_q) ovr_d = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (dv_q && data_ready) begin
            dv_d  = 1'b0;
            ovr_d = 1'b0;
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign frame_err  = oferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = operr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomized bench for uart_rx_param (8 data bits, 16x oversample, 1 stop bit).
module tb_uart_rx_param;

    localparam int BIT_NS = 1600;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic       parity_odd = 1'b0;
    logic       data_ready = 1'b0;
    logic [7:0] data;
    logic       data_valid, frame_err, parity_err, overrun, busy;

    int tests = 0;
    int fails = 0;

    logic [9:0] got_q[$];
    int         vrise = 0;
    logic       dv_prev = 1'b0;

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx), .parity_odd(parity_odd),
        .data(data), .data_valid(data_valid), .data_ready(data_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        int tc;
        tc = 0;
        forever begin
            @(negedge clk);
            tc = (tc == 9) ? 0 : tc + 1;
            baud_tick = (tc == 0);
        end
    end

    // Record every accepted word as {parity_err, frame_err, data}.
    always @(negedge clk) begin
        if (data_valid && data_ready) got_q.push_back({parity_err, frame_err, data});
        if (data_valid && !dv_prev) vrise++;
        dv_prev = data_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = 'x;
        if (got_q.size() > 0) obs = got_q.pop_front();
        check(tag, {22'd0, obs}, {22'd0, exp});
    endtask

    function automatic logic [9:0] model(input logic [7:0] d, input bit stop, input bit par);
        bit pe;
`ifdef UART_RX_PARITY_EN
        pe = (par != ((^d) ^ parity_odd));
`else
        pe = par & 1'b0;
`endif
        return {pe, ~stop, d};
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par, input int gap_ns);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(BIT_NS);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        #(BIT_NS);
`else
        if (par) rx = 1'b1;
`endif
        rx = stop;
        #(BIT_NS);
        rx = 1'b1;
        #(gap_ns);
    endtask

    initial begin
        int         r0;
        logic [7:0] rd;
        bit         rs, rp;

        #100;
        check("rst_data", {24'd0, data}, 32'h0);
        check("rst_valid", {31'd0, data_valid}, 32'h0);
        check("rst_ferr", {31'd0, frame_err}, 32'h0);
        check("rst_perr", {31'd0, parity_err}, 32'h0);
        check("rst_ovr", {31'd0, overrun}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        @(negedge clk); rst = 1'b1;
        #(BIT_NS);

        // Single clean frame with consumer always ready.
        data_ready = 1'b1;
        r0 = vrise;
        send_frame(8'h9A, 1'b1, 1'b0, 200);
        expect_word("t1_word", model(8'h9A, 1'b1, 1'b0));
        check("t1_pulses", vrise - r0, 1);
        check("t1_ovr", {31'd0, overrun}, 32'h0);
        check("t1_valid_low", {31'd0, data_valid}, 32'h0);

        // Randomized frames, including bad stop bits.
        for (int n = 0; n < 10; n++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            rp = 1'($urandom_range(0, 1));
            send_frame(rd, rs, rp, 800);
            expect_word($sformatf("rand%0d", n), model(rd, rs, rp));
        end
        check("rand_extra", got_q.size(), 0);

        // Short low glitch must be rejected.
        r0 = vrise;
        rx = 1'b0; #400; rx = 1'b1;
        #(BIT_NS);
        check("t2_busy", {31'd0, busy}, 32'h0);
        check("t2_pulses", vrise - r0, 0);
        check("t2_valid", {31'd0, data_valid}, 32'h0);

        // Back-to-back frames with consumer stalled.
        data_ready = 1'b0;
        send_frame(8'h9A, 1'b1, 1'b0, 0);
        check("t3_f1_valid", {31'd0, data_valid}, 32'h1);
        check("t3_f1_ovr", {31'd0, overrun}, 32'h0);
        send_frame(8'h9A, 1'b1, 1'b0, 0);
        check("t3_f2_ovr", {31'd0, overrun}, 32'h1);
        send_frame(8'h9A, 1'b1, 1'b0, 200);
        check("t3_f3_data", {24'd0, data}, 32'h9A);
        check("t3_f3_ovr", {31'd0, overrun}, 32'h1);
        @(posedge clk); #1 data_ready = 1'b1;
        @(posedge clk); #1 data_ready = 1'b0;
        check("t3_acc_valid", {31'd0, data_valid}, 32'h0);
        check("t3_acc_ovr", {31'd0, overrun}, 32'h0);
        expect_word("t3_word", model(8'h9A, 1'b1, 1'b0));
        check("t3_extra", got_q.size(), 0);

        // Framing error then a clean frame.
        data_ready = 1'b1;
        send_frame(8'h9A, 1'b0, 1'b0, BIT_NS);
        expect_word("t4_ferr", model(8'h9A, 1'b0, 1'b0));
        send_frame(8'h9B, 1'b1, 1'b1, 400);
        expect_word("t4_clean", model(8'h9B, 1'b1, 1'b1));

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        send_frame(8'h9A, 1'b1, 1'b0, 400);
        expect_word("t5_par_ok", model(8'h9A, 1'b1, 1'b0));
        send_frame(8'h9A, 1'b1, 1'b1, 400);
        expect_word("t5_par_bad", model(8'h9A, 1'b1, 1'b1));
`endif

        // Break: one framing-error word, then silence until the line returns high.
        r0 = vrise;
        rx = 1'b0;
        #(20 * BIT_NS);
        check("brk_pulses", vrise - r0, 1);
        expect_word("brk_word", model(8'h00, 1'b0, 1'b0));
        rx = 1'b1;
        #(BIT_NS);
        send_frame(8'h3C, 1'b1, 1'b0, 400);
        expect_word("brk_after", model(8'h3C, 1'b1, 1'b0));

        // Reset in the middle of the data bits.
        rx = 1'b0; #(BIT_NS);
        rx = 1'b1; #(BIT_NS);
        rx = 1'b0; #(BIT_NS);
        rx = 1'b1; #(BIT_NS / 2);
        rst = 1'b0;
        #100;
        check("t6_busy", {31'd0, busy}, 32'h0);
        check("t6_valid", {31'd0, data_valid}, 32'h0);
        @(negedge clk); rst = 1'b1;
        #(2 * BIT_NS);
        check("t6_no_stale", got_q.size(), 0);
        send_frame(8'h1A, 1'b1, 1'b0, 400);
        expect_word("t6_word", model(8'h1A, 1'b1, 1'b0));
        check("t6_extra", got_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
